// File: rtl/maxima_pkg.sv
// Shared types and constants for the maxima band scheduler.
package maxima_pkg;

    // Scheduler sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_EMIT = 2'd3
    } state_t;

    // Default payload widths of a reduction result
    localparam int DEF_IDX_W = 9;
    localparam int DEF_MAG_W = 16;
    localparam int PEAK_W    = DEF_IDX_W + DEF_MAG_W;

    // Index 0 with magnitude 0: the null peak
    localparam logic [PEAK_W-1:0] NULL_PEAK = '0;

endpackage

// File: rtl/band_timeout_counter.sv
// Watchdog counter for the scheduler's WAIT state; terminal is high
// while the count sits at TIMEOUT-1.
module band_timeout_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] count;

    // Count WAIT cycles; clear has priority over enable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/maxima_band_scheduler.sv
// Sequences the shared max-reduction tree across the bands of each frame
// and streams one {band, index, magnitude} peak per band downstream.
// Optional feature: define MAXIMA_THRESHOLD_EN to replace peaks whose
// magnitude is below `threshold` with the null peak.
module maxima_band_scheduler
    import maxima_pkg::*;
#(
    parameter  int NUM_BANDS = 6,
    parameter  int IDX_W     = DEF_IDX_W,
    parameter  int MAG_W     = DEF_MAG_W,
    parameter  int TIMEOUT   = 64,
    localparam int BAND_W    = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_valid,
    output logic                   frame_ready,
    input  logic [15:0]            frame_id,
    input  logic [MAG_W-1:0]       threshold,
    output logic [BAND_W-1:0]      red_band,
    output logic                   red_load,
    input  logic                   red_active,
    input  logic [IDX_W+MAG_W-1:0] red_max,
    output logic                   peak_valid,
    input  logic                   peak_ready,
    output logic [BAND_W-1:0]      peak_band,
    output logic [IDX_W-1:0]       peak_index,
    output logic [MAG_W-1:0]       peak_mag,
    output logic [15:0]            peak_frame,
    output logic                   peak_last,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int RES_W = IDX_W + MAG_W;

    state_t state;
    state_t next_state;

    logic             accept;
    logic             capture;
    logic             abort;
    logic             handshake;
    logic             last_band;
    logic             terminal;
    logic [RES_W-1:0] shaped;
    logic             frame_ready_d;
    logic             red_load_d;
    logic             peak_valid_d;
    logic             busy_d;

    // red_band doubles as the current-band register
    assign last_band = (red_band == BAND_W'(NUM_BANDS - 1));
    assign accept    = (state == ST_IDLE) && frame_valid && frame_ready;
    assign capture   = (state == ST_WAIT) && red_active;
    assign abort     = (state == ST_WAIT) && !red_active && terminal;
    assign handshake = (state == ST_EMIT) && peak_ready;

`ifdef MAXIMA_THRESHOLD_EN
    function automatic logic [RES_W-1:0] apply_threshold(
        input logic [RES_W-1:0] res,
        input logic [MAG_W-1:0] thr
    );
        if (res[MAG_W-1:0] < thr) begin
            return RES_W'(NULL_PEAK);
        end
        return res;
    endfunction

    assign shaped = apply_threshold(red_max, threshold);
`else
    logic unused_threshold;
    assign unused_threshold = ^threshold;
    assign shaped           = red_max;
`endif

    band_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == ST_LOAD),
        .enable   ((state == ST_WAIT) && !red_active),
        .terminal (terminal)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a result arriving on the terminal cycle wins over abort
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept)    next_state = ST_LOAD;
            ST_LOAD:                next_state = ST_WAIT;
            ST_WAIT: if (capture)   next_state = ST_EMIT;
                     else if (abort) next_state = ST_IDLE;
            ST_EMIT: if (handshake) next_state = last_band ? ST_IDLE : ST_LOAD;
            default:                next_state = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every flag is registered
    always_comb begin
        frame_ready_d = (next_state == ST_IDLE);
        red_load_d    = (next_state == ST_LOAD);
        peak_valid_d  = (next_state == ST_EMIT);
        busy_d        = (next_state != ST_IDLE);
    end

    // Registered control flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_ready <= 1'b0;
            red_load    <= 1'b0;
            peak_valid  <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            frame_ready <= frame_ready_d;
            red_load    <= red_load_d;
            peak_valid  <= peak_valid_d;
            busy        <= busy_d;
            timeout_err <= timeout_err | abort;
        end
    end

    // Band pointer, frame tag and peak payload capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            red_band               <= '0;
            peak_frame             <= '0;
            peak_band              <= '0;
            peak_last              <= 1'b0;
            {peak_index, peak_mag} <= RES_W'(NULL_PEAK);
        end else begin
            if (accept) begin
                red_band   <= '0;
                peak_frame <= frame_id;
            end else if (handshake && !last_band) begin
                red_band <= red_band + BAND_W'(1);
            end
            if (capture) begin
                peak_band              <= red_band;
                peak_last              <= last_band;
                {peak_index, peak_mag} <= shaped;
            end
        end
    end

endmodule

// File: tb/tb_maxima_band_scheduler.sv
// Directed bench for maxima_band_scheduler (NUM_BANDS=6, TIMEOUT=64,
// reduction latency 3 emulated by the stimulus sequence).
module tb_maxima_band_scheduler;

    localparam int NB = 6;
    localparam int IW = 9;
    localparam int MW = 16;
    localparam int BW = 3;
    localparam int L  = 3;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_valid;
    logic          frame_ready;
    logic [15:0]   frame_id;
    logic [MW-1:0] threshold;
    logic [BW-1:0] red_band;
    logic          red_load;
    logic          red_active;
    logic [IW+MW-1:0] red_max;
    logic          peak_valid;
    logic          peak_ready;
    logic [BW-1:0] peak_band;
    logic [IW-1:0] peak_index;
    logic [MW-1:0] peak_mag;
    logic [15:0]   peak_frame;
    logic          peak_last;
    logic          busy;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    maxima_band_scheduler #(
        .NUM_BANDS (NB),
        .IDX_W     (IW),
        .MAG_W     (MW),
        .TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_id    (frame_id),
        .threshold   (threshold),
        .red_band    (red_band),
        .red_load    (red_load),
        .red_active  (red_active),
        .red_max     (red_max),
        .peak_valid  (peak_valid),
        .peak_ready  (peak_ready),
        .peak_band   (peak_band),
        .peak_index  (peak_index),
        .peak_mag    (peak_mag),
        .peak_frame  (peak_frame),
        .peak_last   (peak_last),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept_frame(input logic [15:0] id, input bit hold);
        check("ready_before_accept", frame_ready, 1);
        frame_id    = id;
        frame_valid = 1'b1;
        tick();
        cyc = 0;
        if (!hold) frame_valid = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_ready_low", frame_ready, 0);
        check("accept_load", red_load, 1);
        check("accept_band0", red_band, 0);
        check("accept_tag", peak_frame, id);
    endtask

    // One band: load seen, L-cycle reduction, capture, optional stall, handshake
    task automatic do_band(input int b, input int idx, input int mag,
                           input int stall, input bit spurious);
        int n;
        logic [IW-1:0] ei;
        logic [MW-1:0] em;
        n = 0;
        while (red_load !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("load", red_load, 1);
        check("load_band", red_band, b);
        tick();
        check("load_one_cycle", red_load, 0);
        check("band_held", red_band, b);
        repeat (L) tick();
        red_active = 1'b1;
        red_max    = {IW'(idx), MW'(mag)};
        tick();
        red_active = 1'b0;
        red_max    = '1;
        ei = IW'(idx);
        em = MW'(mag);
`ifdef MAXIMA_THRESHOLD_EN
        if (MW'(mag) < threshold) begin
            ei = '0;
            em = '0;
        end
`endif
        check("peak_valid", peak_valid, 1);
        check("peak_band", peak_band, b);
        check("peak_index", peak_index, ei);
        check("peak_mag", peak_mag, em);
        check("peak_last", peak_last, (b == NB - 1));
        if (stall > 0) begin
            peak_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                if (spurious) begin
                    red_active = 1'b1;
                    red_max    = {IW'(1), MW'(16'h7777)};
                end
                tick();
                check("stall_valid", peak_valid, 1);
                check("stall_index", peak_index, ei);
                check("stall_mag", peak_mag, em);
                check("stall_no_load", red_load, 0);
            end
            red_active = 1'b0;
            peak_ready = 1'b1;
        end
        tick();
        check("after_hs_valid", peak_valid, 0);
        if (b < NB - 1) begin
            check("next_load", red_load, 1);
            check("next_band", red_band, b + 1);
        end else begin
            check("frame_done_idle", busy, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        frame_valid = 1'b0;
        frame_id    = '0;
        threshold   = '0;
        red_active  = 1'b0;
        red_max     = '0;
        peak_ready  = 1'b1;

        // Reset state
        repeat (3) tick();
        check("rst_frame_ready", frame_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_red_load", red_load, 0);
        check("rst_peak_valid", peak_valid, 0);
        check("rst_timeout_err", timeout_err, 0);
        reset = 1'b1;
        tick();
        check("ready_after_reset", frame_ready, 1);

        // Frame A: plain six-band frame, ready tied high
        accept_frame(16'hA001, 1'b0);
        for (int b = 0; b < NB; b++) do_band(b, b + 10, 100 * b, 0, 1'b0);
        check("frame_cycles", cyc, NB * (L + 3));
        check("frame_ready_after", frame_ready, 1);

        // Frame B: frame_valid held while busy, stall plus stray result on band 2
        accept_frame(16'hB002, 1'b1);
        frame_id = 16'hFFFF;
        for (int b = 0; b < NB - 1; b++) begin
            do_band(b, b + 20, 50 * b + 1, (b == 2) ? 5 : 0, (b == 2));
            check("ready_low_busy", frame_ready, 0);
            check("tag_kept", peak_frame, 16'hB002);
        end
        frame_valid = 1'b0;
        do_band(NB - 1, 25, 251, 0, 1'b0);
        check("last_tag", peak_frame, 16'hB002);

        // Frame C: result on the terminal WAIT cycle, then a real timeout
        accept_frame(16'hC003, 1'b0);
        check("c_load0", red_load, 1);
        repeat (TO) tick();
        check("c_late_busy", busy, 1);
        check("c_late_noerr", timeout_err, 0);
        red_active = 1'b1;
        red_max    = {IW'(5), MW'(1234)};
        tick();
        red_active = 1'b0;
        check("c_late_valid", peak_valid, 1);
        check("c_late_mag", peak_mag, 1234);
        check("c_late_noerr2", timeout_err, 0);
        tick();
        check("c_load1", red_load, 1);
        check("c_band1", red_band, 1);
        repeat (TO) tick();
        check("c_wait_busy", busy, 1);
        check("c_wait_noerr", timeout_err, 0);
        tick();
        check("c_timeout_err", timeout_err, 1);
        check("c_timeout_ready", frame_ready, 1);
        check("c_timeout_idle", busy, 0);
        check("c_timeout_noload", red_load, 0);
        repeat (3) tick();
        check("c_no_band2_load", red_load, 0);
        check("c_no_peak", peak_valid, 0);

        // Frame D: error persists, then reset in WAIT of band 4
        accept_frame(16'hD004, 1'b0);
        check("d_err_sticky", timeout_err, 1);
        for (int b = 0; b < 4; b++) do_band(b, b + 30, 10 * b, 0, 1'b0);
        check("d_load4", red_load, 1);
        check("d_band4", red_band, 4);
        tick();
        tick();
        reset = 1'b0;
        #2;
        check("ar_frame_ready", frame_ready, 0);
        check("ar_busy", busy, 0);
        check("ar_red_load", red_load, 0);
        check("ar_red_band", red_band, 0);
        check("ar_peak_valid", peak_valid, 0);
        check("ar_peak_index", peak_index, 0);
        check("ar_peak_mag", peak_mag, 0);
        check("ar_peak_band", peak_band, 0);
        check("ar_peak_frame", peak_frame, 0);
        check("ar_peak_last", peak_last, 0);
        check("ar_timeout_err", timeout_err, 0);
        tick();
        reset = 1'b1;
        tick();
        check("ar_ready_back", frame_ready, 1);

        // Frame E: restart at band 0, magnitudes just below / at threshold
        threshold = 16'd500;
        accept_frame(16'hE005, 1'b0);
        do_band(0, 7, 499, 0, 1'b0);
        do_band(1, 8, 500, 0, 1'b0);
        threshold = '0;
        for (int b = 2; b < NB; b++) do_band(b, b, b, 0, 1'b0);
        check("e_no_err", timeout_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
